writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/cpu_types_pkg.sv | 37 +++
 rtl/writeback_if.sv | 61 ++++++
 rtl/writeback_stage.sv | 83 ++++++++
 tb/tb_writeback_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: writeback source encoding, MEM/WB latch layout and the
// writeback result selector.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_NPC  = 2'd2,
      WB_LUI  = 2'd3
   } wbsrc_t;

   typedef struct packed {
      logic        valid;
      logic        regwr;
      logic [4:0]  wsel;
      wbsrc_t      wbsrc;
      logic [31:0] aluout;
      logic [31:0] dload;
      logic [31:0] npc;
      logic [15:0] imm16;
      logic        halt;
   } memwb_t;

   function automatic logic [31:0] wb_result(memwb_t l);
      logic [31:0] r;
      r = l.aluout;
      case (l.wbsrc)
         WB_ALU:  r = l.aluout;
         WB_LOAD: r = l.dload;
         WB_NPC:  r = l.npc;
         WB_LUI:  r = {l.imm16, 16'h0000};
         default: r = l.aluout;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/writeback_if.sv
// Port bundle between MEM and the writeback stage.
// `WB_RETIRE_CNT_EN adds the retired-instruction count.
interface writeback_if #(
   parameter int unsigned RETIRE_W = 32
) ();

   logic        mem_valid;
   logic        mem_regwr;
   logic [4:0]  mem_wsel;
   logic [1:0]  mem_wbsrc;
   logic [31:0] mem_aluout;
   logic [31:0] mem_dload;
   logic [31:0] mem_npc;
   logic [15:0] mem_imm16;
   logic        mem_halt;
   logic        wb_en;
   logic        wb_flush;

   logic        WEN;
   logic [4:0]  wsel;
   logic [31:0] wdat;
   logic        fwd_valid;
   logic [4:0]  fwd_sel;
   logic [31:0] fwd_dat;
   logic        halt;

`ifdef WB_RETIRE_CNT_EN
   logic [RETIRE_W-1:0] retired;
`else
   logic unused_retire_w;
   assign unused_retire_w = ^RETIRE_W;
`endif

   modport wb (
`ifdef WB_RETIRE_CNT_EN
      output retired,
`endif
      input  mem_valid, mem_regwr, mem_wsel, mem_wbsrc, mem_aluout, mem_dload, mem_npc,
             mem_imm16, mem_halt, wb_en, wb_flush,
      output WEN, wsel, wdat, fwd_valid, fwd_sel, fwd_dat, halt
   );

   modport mem (
`ifdef WB_RETIRE_CNT_EN
      input  retired,
`endif
      output mem_valid, mem_regwr, mem_wsel, mem_wbsrc, mem_aluout, mem_dload, mem_npc,
             mem_imm16, mem_halt, wb_en, wb_flush,
      input  WEN, wsel, wdat, fwd_valid, fwd_sel, fwd_dat, halt
   );

   modport tb (
`ifdef WB_RETIRE_CNT_EN
      input  retired,
`endif
      output mem_valid, mem_regwr, mem_wsel, mem_wbsrc, mem_aluout, mem_dload, mem_npc,
             mem_imm16, mem_halt, wb_en, wb_flush,
      input  WEN, wsel, wdat, fwd_valid, fwd_sel, fwd_dat, halt
   );

endinterface

// File: rtl/writeback_stage.sv
// MEM/WB latch and register-file write port, with sticky HALT.
// `WB_RETIRE_CNT_EN adds a saturating retired-instruction counter.
module writeback_stage
   import cpu_types_pkg::*;
#(
   parameter int unsigned RETIRE_W = 32
) (
   input  logic   CLK,
   input  logic   nRST,
   writeback_if.wb bus
);

   memwb_t      latch_q, latch_d;
   logic        halted;
   logic        capture;
   logic        wen;
   logic [31:0] result;

   // A latched valid HALT is the halt flag; the latch then never changes again.
   assign halted = latch_q.valid & latch_q.halt;
   assign capture = ~halted & bus.wb_en & ~bus.wb_flush;

   always_comb begin
      latch_d = latch_q;
      if (!halted && bus.wb_flush) begin
         latch_d.valid = 1'b0;
      end else if (capture) begin
         latch_d.valid  = bus.mem_valid;
         latch_d.regwr  = bus.mem_regwr;
         latch_d.wsel   = bus.mem_wsel;
         latch_d.wbsrc  = wbsrc_t'(bus.mem_wbsrc);
         latch_d.aluout = bus.mem_aluout;
         latch_d.dload  = bus.mem_dload;
         latch_d.npc    = bus.mem_npc;
         latch_d.imm16  = bus.mem_imm16;
         latch_d.halt   = bus.mem_halt;
      end
   end

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         latch_q <= '0;
      end else begin
         latch_q <= latch_d;
      end
   end

   assign wen    = latch_q.valid & latch_q.regwr & (latch_q.wsel != 5'd0) & ~halted;
   assign result = wb_result(latch_q);

   assign bus.WEN       = wen;
   assign bus.wsel      = latch_q.wsel;
   assign bus.wdat      = result;
   assign bus.fwd_valid = wen;
   assign bus.fwd_sel   = latch_q.wsel;
   assign bus.fwd_dat   = result;
   assign bus.halt      = halted;

`ifdef WB_RETIRE_CNT_EN
   logic [RETIRE_W-1:0] retired_q, retired_d;

   always_comb begin
      retired_d = retired_q;
      if (capture && bus.mem_valid && !(&retired_q)) begin
         retired_d = retired_q + 1'b1;
      end
   end

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         retired_q <= '0;
      end else begin
         retired_q <= retired_d;
      end
   end

   assign bus.retired = retired_q;
`else
   logic unused_retire_w;
   assign unused_retire_w = ^RETIRE_W;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed cases then random traffic,
// checked against a transaction-level model of the MEM/WB behaviour.
module tb_writeback_stage;
   import cpu_types_pkg::*;

`ifdef WB_RETIRE_CNT_EN
   localparam int unsigned RW = 4;
`else
   localparam int unsigned RW = 32;
`endif
   localparam longint unsigned RMAX = (64'd1 << RW) - 64'd1;

   logic CLK = 1'b0;
   logic nRST = 1'b0;

   writeback_if #(.RETIRE_W(RW)) bus ();

   writeback_stage #(.RETIRE_W(RW)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit          wen;
      bit [4:0]    wsel;
      bit [31:0]   wdat;
      bit          chk_dat;
      bit          halt;
      longint unsigned retired;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: the instruction most recently accepted by the stage.
   bit              m_valid, m_regwr, halted;
   bit [4:0]        m_wsel;
   bit [1:0]        m_src;
   bit [31:0]       m_alu, m_dload, m_npc;
   bit [15:0]       m_imm;
   longint unsigned m_ret;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_regwr = 0; halted = 0; m_wsel = 0; m_src = 0;
      m_alu = 0; m_dload = 0; m_npc = 0; m_imm = 0; m_ret = 0;
   endtask

   task automatic model_edge();
      if (!halted) begin
         if (bus.wb_flush) begin
            m_valid = 0;
         end else if (bus.wb_en) begin
            m_valid = bus.mem_valid;   m_regwr = bus.mem_regwr;
            m_wsel  = bus.mem_wsel;    m_src   = bus.mem_wbsrc;
            m_alu   = bus.mem_aluout;  m_dload = bus.mem_dload;
            m_npc   = bus.mem_npc;     m_imm   = bus.mem_imm16;
            if (bus.mem_valid) begin
               if (m_ret < RMAX) m_ret++;
               if (bus.mem_halt) halted = 1;
            end
         end
      end
   endtask

   function automatic exp_t model_out(input bit in_rst);
      exp_t e;
      e.wen  = m_valid && m_regwr && (m_wsel != 0) && !halted;
      e.wsel = m_wsel;
      case (m_src)
         2'd0: e.wdat = m_alu;
         2'd1: e.wdat = m_dload;
         2'd2: e.wdat = m_npc;
         default: e.wdat = {m_imm, 16'h0000};
      endcase
      e.chk_dat = m_valid || in_rst;
      e.halt    = halted;
      e.retired = m_ret;
      return e;
   endfunction

   // Monitor: one expected entry per cycle, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wen",       {63'd0, bus.WEN},       {63'd0, e.wen});
            check("fwd_valid", {63'd0, bus.fwd_valid}, {63'd0, e.wen});
            check("wsel",      {59'd0, bus.wsel},      {59'd0, e.wsel});
            check("fwd_sel",   {59'd0, bus.fwd_sel},   {59'd0, e.wsel});
            check("halt",      {63'd0, bus.halt},      {63'd0, e.halt});
            if (e.chk_dat) begin
               check("wdat",    {32'd0, bus.wdat},    {32'd0, e.wdat});
               check("fwd_dat", {32'd0, bus.fwd_dat}, {32'd0, e.wdat});
            end
`ifdef WB_RETIRE_CNT_EN
            check("retired", 64'(bus.retired), e.retired);
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic drive(input bit v, input bit rw, input bit [4:0] sel, input bit [1:0] src,
                        input bit [31:0] alu, input bit [31:0] dl, input bit [31:0] npc,
                        input bit [15:0] imm, input bit h, input bit en, input bit fl);
      bus.mem_valid = v;   bus.mem_regwr = rw;   bus.mem_wsel = sel;  bus.mem_wbsrc = src;
      bus.mem_aluout = alu; bus.mem_dload = dl;  bus.mem_npc = npc;   bus.mem_imm16 = imm;
      bus.mem_halt = h;    bus.wb_en = en;       bus.wb_flush = fl;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      if (nRST) model_edge();
      exp_q.push_back(model_out(!nRST));
   endtask

   task automatic drive_rand();
      bit [4:0] sel;
      sel = 5'($urandom);
      if ($urandom_range(0, 7) == 0) sel = 0;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, sel, 2'($urandom),
            $urandom, $urandom, $urandom, 16'($urandom), $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
   endtask

   // Reset asserted mid-cycle, held across one edge, released mid-cycle.
   task automatic reset_mid();
      step();
      #2;
      nRST = 1'b0;
      #1;
      check("rst_wen_async",  {63'd0, bus.WEN},  64'd0);
      check("rst_halt_async", {63'd0, bus.halt}, 64'd0);
      model_reset();
      exp_q.delete();
      exp_q.push_back(model_out(1'b1));
      step();
      #2;
      nRST = 1'b1;
   endtask

   initial begin
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      #2;
      nRST = 1'b1;

      // ALU write to r5
      drive(1, 1, 5, 0, 32'hDEADBEEF, 32'h1111, 32'h2222, 16'h3333, 0, 1, 0);
      step();
      // LUI to r8, then to r0
      drive(1, 1, 8, 3, 32'h5, 32'h6, 32'h7, 16'h1234, 0, 1, 0);
      step();
      drive(1, 1, 0, 3, 32'h5, 32'h6, 32'h7, 16'h1234, 0, 1, 0);
      step();
      // Capture, then stall three cycles with different inputs present
      drive(1, 1, 7, 0, 32'h0000CAFE, 0, 0, 0, 0, 1, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 9, 1, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0, 0, 0, 0);
         step();
      end
      // Flush beats enable
      drive(1, 1, 9, 1, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0, 0, 1, 1);
      step();
      // LOAD and NPC sources
      drive(1, 1, 3, 1, 32'h1, 32'h87654321, 32'h2, 0, 0, 1, 0);
      step();
      drive(1, 1, 31, 2, 32'h1, 32'h2, 32'h00400008, 0, 0, 1, 0);
      step();
      // HALT, then later traffic must not move the latch
      drive(1, 1, 4, 0, 32'h44, 0, 0, 0, 1, 1, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 6, 0, 32'h600D + i, 0, 0, 0, 0, 1, i == 1);
         step();
      end
      // Reset after halt, then a write in flight when reset hits
      reset_mid();
      drive(1, 1, 12, 0, 32'h12121212, 0, 0, 0, 0, 1, 0);
      step();
      reset_mid();

      // Retire count: 10 valid, 2 bubbles, 1 flush; then drive into saturation
      for (int i = 0; i < 13; i++) begin
         if (i == 4 || i == 9) drive(0, 1, 2, 0, i, 0, 0, 0, 0, 1, 0);
         else if (i == 6)      drive(1, 1, 2, 0, i, 0, 0, 0, 0, 1, 1);
         else                  drive(1, 1, 2, 0, i, 0, 0, 0, 0, 1, 0);
         step();
      end
      for (int i = 0; i < 12; i++) begin
         drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
         step();
      end

      // Random traffic with occasional resets
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 49) == 0) begin
            reset_mid();
         end else begin
            drive_rand();
            step();
         end
      end

      @(negedge CLK);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
